// File: rtl/wb_arbiter.sv
// Writeback arbiter: seven sources plus an exception write share one
// register-file write port through an 8-way data mux.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   req[6:0]        one-cycle request pulse per writeback source
//   dest_in[34:0]   5-bit destination per source, sampled with req[k]
//   exc_req         request to write the mux constant (code 7)
//   mux_sel[2:0]    registered mux select
//   reg_wr          register-file write enable
//   wr_addr[4:0]    registered write address
//   grant[7:0]      one-hot completion pulse, bit 7 = exception
//   busy            work pending or in service
//   err             sticky: a request was lost
module wb_arbiter #(
  parameter logic [4:0] EXC_DEST = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  req,
  input  logic [34:0] dest_in,
  input  logic        exc_req,
  output logic [2:0]  mux_sel,
  output logic        reg_wr,
  output logic [4:0]  wr_addr,
  output logic [7:0]  grant,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WRITE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  pend;
  logic [4:0]  dst [8];
  logic [2:0]  win;
  logic [2:0]  rr_ptr;
  logic        wr_q;
  logic [7:0]  gnt_q;

  logic [7:0]  reqv;
  logic [7:0]  in_wr;
  logic [7:0]  avail;
  logic        lost;
  logic [2:0]  ptr;
  logic [2:0]  pick;
  logic        found;

  assign reqv = {exc_req, req};

  // The source in its write cycle is treated as already retired, so a
  // fresh request from it is accepted and it is excluded from selection.
  always_comb begin
    in_wr = '0;
    if (state == WRITE) in_wr[win] = 1'b1;
  end

  assign avail = pend & ~in_wr;
  assign lost  = |(reqv & avail);

  // Selection at the end of a write already uses the advanced pointer.
  always_comb begin
    ptr = rr_ptr;
    if (state == WRITE && win != 3'd7)
      ptr = (win == 3'd6) ? 3'd0 : win + 3'd1;
  end

  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    if (avail[7]) begin
      found = 1'b1;
      pick  = 3'd7;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (!found && avail[(int'(ptr) + i) % 7]) begin
          found = 1'b1;
          pick  = 3'((int'(ptr) + i) % 7);
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = found ? SETUP : IDLE;
      SETUP:   state_nx = WRITE;
      WRITE:   state_nx = found ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pend    <= '0;
      for (int k = 0; k < 8; k++) dst[k] <= '0;
      win     <= '0;
      rr_ptr  <= '0;
      mux_sel <= '0;
      wr_addr <= '0;
      wr_q    <= 1'b0;
      gnt_q   <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      pend  <= avail | reqv;
      for (int k = 0; k < 7; k++)
        if (reqv[k] && !avail[k]) dst[k] <= dest_in[5*k +: 5];
      if (exc_req && !avail[7]) dst[7] <= EXC_DEST;
      if (lost) err <= 1'b1;
      if (state == WRITE && win != 3'd7) rr_ptr <= ptr;
      if (state_nx == SETUP) begin
        win     <= pick;
        mux_sel <= pick;
        wr_addr <= dst[pick];
      end
      wr_q  <= (state_nx == WRITE) && (wr_addr != 5'd0);
      gnt_q <= (state_nx == WRITE) ? (8'd1 << win) : 8'd0;
    end
  end

  // Reset arriving in the write cycle kills the strobes immediately.
  assign reg_wr = wr_q & ~reset;
  assign grant  = gnt_q & {8{~reset}};
  assign busy   = (|pend) || (state != IDLE);

endmodule
